// File: rtl/scarv_cop_cpr_wb.sv
// CPR write-back queue: buffers execution-unit register writes in a circular
// FIFO and drains them into the CPR write port, tracking pending targets.
module scarv_cop_cpr_wb #(
    parameter int DEPTH = 4
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  wb_addr,
    input  logic [3:0]  wb_ben,
    input  logic [31:0] wb_wdata,
    input  logic        wb_last,
    input  logic        wb_flush,
    input  logic        cpr_stall,
    output logic        cpr_we,
    output logic [3:0]  cpr_waddr,
    output logic [3:0]  cpr_ben,
    output logic [31:0] cpr_wdata,
    output logic [15:0] busy_mask,
    output logic        insn_done,
    output logic [4:0]  count
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [4:0]      DEPTH_CNT = 5'(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);

    typedef struct packed {
        logic [3:0]  addr;
        logic [3:0]  ben;
        logic [31:0] wdata;
        logic        last;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [AW-1:0]   head_q;
    logic [AW-1:0]   tail_q;
    logic [4:0]      count_q;

    entry_t head;
    logic   full;
    logic   empty;
    logic   push;
    logic   pop;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == 5'd0);
    assign head  = mem[head_q];

    // Reset and flush both suppress the enqueue; reset also blocks the retire.
    assign wb_ready = !full;
    assign push     = wb_valid && !full && !wb_flush && !g_reset;
    assign pop      = !empty && !cpr_stall && !g_reset;

    assign cpr_we    = pop && (|head.ben);
    assign insn_done = pop && head.last;
    assign cpr_waddr = empty ? 4'd0  : head.addr;
    assign cpr_ben   = empty ? 4'd0  : head.ben;
    assign cpr_wdata = empty ? 32'd0 : head.wdata;
    assign count     = count_q;

    // NOTE: the payload array is deliberately not reset; occupancy lives in
    // valid_q and the pointers, so stale payload is never observable.
    always_ff @(posedge g_clk) begin
        if (push) begin
            mem[tail_q] <= {wb_addr, wb_ben, wb_wdata, wb_last};
        end
    end

    // NOTE: all state registers use non-blocking assignments so every
    // update in this block sees the pre-edge values of the others.
    always_ff @(posedge g_clk) begin
        if (g_reset || wb_flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + PTR_ONE;
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + PTR_ONE;
            end
            if (push && !pop) begin
                count_q <= count_q + 5'd1;
            end else if (pop && !push) begin
                count_q <= count_q - 5'd1;
            end
        end
    end

    // NOTE: the default assignment first keeps this combinational block
    // from inferring latches on the bits no entry targets.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (|mem[i].ben)) begin
                busy_mask[mem[i].addr] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scarv_cop_cpr_wb.sv
// Scoreboard bench for scarv_cop_cpr_wb: accepted requests queue an expected
// retirement, and a negedge monitor compares every write / insn_done pulse.
module tb_scarv_cop_cpr_wb;

    logic        g_clk;
    logic        g_reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_addr;
    logic [3:0]  wb_ben;
    logic [31:0] wb_wdata;
    logic        wb_last;
    logic        wb_flush;
    logic        cpr_stall;
    logic        cpr_we;
    logic [3:0]  cpr_waddr;
    logic [3:0]  cpr_ben;
    logic [31:0] cpr_wdata;
    logic [15:0] busy_mask;
    logic        insn_done;
    logic [4:0]  count;

    scarv_cop_cpr_wb #(.DEPTH(4)) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_ben    (wb_ben),
        .wb_wdata  (wb_wdata),
        .wb_last   (wb_last),
        .wb_flush  (wb_flush),
        .cpr_stall (cpr_stall),
        .cpr_we    (cpr_we),
        .cpr_waddr (cpr_waddr),
        .cpr_ben   (cpr_ben),
        .cpr_wdata (cpr_wdata),
        .busy_mask (busy_mask),
        .insn_done (insn_done),
        .count     (count)
    );

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [3:0]  ben;
        logic [31:0] data;
        logic        done;
    } exp_t;

    exp_t exp_q [$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   stream_done;

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every observable retirement must match the oldest expectation.
    always @(negedge g_clk) begin : monitor
        exp_t e;
        if (!g_reset && (cpr_we || insn_done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_retire", {62'd0, cpr_we, insn_done}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("retire", {22'd0, cpr_we, cpr_waddr, cpr_ben, cpr_wdata, insn_done},
                      {22'd0, e.we, e.addr, e.ben, e.data, e.done});
            end
        end
    end

    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [31:0] d,
                        input logic l);
        bit ok = 1'b0;
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_ben   = b;
        wb_wdata = d;
        wb_last  = l;
        for (int g = 0; g < 200 && !ok; g++) begin
            @(negedge g_clk);
            if (wb_ready) ok = 1'b1;
            @(posedge g_clk);
            #1;
        end
        wb_valid = 1'b0;
        if (!ok) check("push_timeout", 64'd0, 64'd1);
        else if (b != 4'd0 || l) exp_q.push_back('{we: |b, addr: a, ben: b, data: d, done: l});
    endtask

    task automatic wait_empty(input string name);
        for (int g = 0; g < 200; g++) begin
            @(negedge g_clk);
            if (count == 5'd0) break;
        end
        check(name, {59'd0, count}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        g_reset = 1'b1; wb_valid = 1'b0; wb_addr = '0; wb_ben = '0; wb_wdata = '0;
        wb_last = 1'b0; wb_flush = 1'b0; cpr_stall = 1'b0; stream_done = 1'b0;
        repeat (2) @(posedge g_clk);
        #1 g_reset = 1'b0;

        // Reset state
        @(negedge g_clk);
        check("rst_ready", {63'd0, wb_ready}, 64'd1);
        check("rst_we_done", {62'd0, cpr_we, insn_done}, 64'd0);
        check("rst_busy", {48'd0, busy_mask}, 64'd0);
        check("rst_count", {59'd0, count}, 64'd0);
        check("rst_outs", {24'd0, cpr_waddr, cpr_ben, cpr_wdata}, 64'd0);

        // Single write through an empty, unstalled queue
        @(posedge g_clk); #1;
        push(4'd3, 4'hF, 32'hDEADBEEF, 1'b1);
        @(negedge g_clk);
        check("lat_write", {22'd0, cpr_we, cpr_waddr, cpr_ben, cpr_wdata, insn_done},
              {22'd0, 1'b1, 4'd3, 4'hF, 32'hDEADBEEF, 1'b1});
        @(posedge g_clk); @(negedge g_clk);
        check("lat_count", {59'd0, count}, 64'd0);

        // Fill under stall, then drain in order
        @(posedge g_clk); #1 cpr_stall = 1'b1;
        push(4'd1, 4'hF, 32'h11111111, 1'b0);
        push(4'd2, 4'h3, 32'h22222222, 1'b0);
        push(4'd7, 4'hC, 32'h33333333, 1'b0);
        push(4'd9, 4'h1, 32'h44444444, 1'b1);
        @(negedge g_clk);
        check("full_ready", {63'd0, wb_ready}, 64'd0);
        check("full_count", {59'd0, count}, 64'd4);
        check("full_busy", {48'd0, busy_mask}, 64'h0286);
        wb_valid = 1'b1; wb_addr = 4'hE; wb_ben = 4'hF; wb_wdata = 32'hBAD0BAD0; wb_last = 1'b1;
        @(posedge g_clk); #1;
        @(negedge g_clk);
        check("full_stalled_noenq", {59'd0, count}, 64'd4);
        @(posedge g_clk); #1 cpr_stall = 1'b0;
        @(posedge g_clk); #1 wb_valid = 1'b0;
        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        check("drain_consecutive", {59'd0, count}, 64'd0);

        // Zero-byte-enable last entry
        @(posedge g_clk); #1 cpr_stall = 1'b1;
        push(4'd5, 4'h0, 32'h55555555, 1'b1);
        @(negedge g_clk);
        check("ben0_busy", {48'd0, busy_mask}, 64'd0);
        check("ben0_count", {59'd0, count}, 64'd1);
        @(posedge g_clk); #1 cpr_stall = 1'b0;
        @(negedge g_clk);
        check("ben0_retire", {62'd0, cpr_we, insn_done}, 64'b01);
        @(posedge g_clk); @(negedge g_clk);
        check("ben0_count_after", {59'd0, count}, 64'd0);

        // Flush with three queued and a request in the flush cycle
        @(posedge g_clk); #1 cpr_stall = 1'b1;
        push(4'hA, 4'hF, 32'hAAAA0001, 1'b0);
        push(4'hB, 4'hF, 32'hAAAA0002, 1'b1);
        push(4'hC, 4'hF, 32'hAAAA0003, 1'b1);
        cpr_stall = 1'b0; wb_flush = 1'b1;
        wb_valid = 1'b1; wb_addr = 4'hD; wb_ben = 4'hF; wb_wdata = 32'hDDDDDDDD; wb_last = 1'b1;
        @(negedge g_clk);
        check("flush_head_write", {59'd0, cpr_we, cpr_waddr}, {59'd0, 1'b1, 4'hA});
        @(posedge g_clk); #1;
        wb_flush = 1'b0; wb_valid = 1'b0;
        exp_q.delete();
        @(negedge g_clk);
        check("flush_count", {59'd0, count}, 64'd0);
        check("flush_busy", {48'd0, busy_mask}, 64'd0);
        repeat (4) @(posedge g_clk);
        @(negedge g_clk);
        check("flush_dropped", {59'd0, count}, 64'd0);

        // Stream of 20 with random stall (pointer wrap)
        @(posedge g_clk); #1;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    push(4'(i), (i == 9) ? 4'h0 : 4'((i % 15) + 1), 32'hC0000000 + 32'(i),
                         (i % 3) == 0);
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge g_clk); #1;
                    cpr_stall = 1'($urandom_range(0, 1));
                end
                cpr_stall = 1'b0;
            end
        join
        wait_empty("stream_drain");
        check("stream_all_seen", 64'(exp_q.size()), 64'd0);

        // Reset with two queued entries
        @(posedge g_clk); #1 cpr_stall = 1'b1;
        push(4'd6, 4'hF, 32'h66666666, 1'b1);
        push(4'd8, 4'hF, 32'h88888888, 1'b1);
        g_reset = 1'b1; cpr_stall = 1'b0;
        exp_q.delete();
        @(negedge g_clk);
        check("rst_cycle_we", {62'd0, cpr_we, insn_done}, 64'd0);
        @(posedge g_clk); #1 g_reset = 1'b0;
        @(negedge g_clk);
        check("rst_mid_count", {59'd0, count}, 64'd0);
        check("rst_mid_we", {63'd0, cpr_we}, 64'd0);
        repeat (4) @(posedge g_clk);
        @(negedge g_clk);
        check("rst_mid_busy", {48'd0, busy_mask}, 64'd0);
        check("leftover_expected", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
